predicate_hazard_issue_controller: RTL and testbench
====================================================

// Module: predicate_hazard_issue_controller
// PURPOSE
//   Issue controller for the PE trigger stage. Tracks each instruction's destination type
//   through the downstream pipeline stages. Holds back issue while a predicate-writing
//   instruction is in flight.
//   Sits between trigger resolution and the first downstream stage. Owns the stage
//   occupancy/DT registers that feed the downstream control-hazard check.
// PARAMETERS
//   NUM_DOWNSTREAM_STAGES  3   stages between trigger and predicate writeback (>=1)
//   COUNTER_WIDTH          16  width of hazard-stall performance counter
//   (TIA_DT_WIDTH, TIA_DESTINATION_TYPE_PREDICATE come from control.svh)
// PORTS
//   clock                  in   1                          core clock
//   reset                  in   1                          async, active-high
//   trigger_valid          in   1                          trigger stage has a selected instruction
//   trigger_dt             in   TIA_DT_WIDTH               destination type of that instruction
//   downstream_stall       in   1                          freeze all downstream stages this cycle
//   flush                  in   1                          quash all in-flight instructions
//   counter_clear          in   1                          sync clear of stall counter
//   issue                  out  1                          instruction advances into stage 0 this cycle
//   hazard                 out  1                          predicate write in flight
//   stage_valid            out  NUM_DOWNSTREAM_STAGES      occupancy, bit i = stage i
//   stage_dt               out  NUM_DOWNSTREAM_STAGES*TIA_DT_WIDTH  DT per stage, stage i at [i*W +: W]
//   predicate_retire       out  1                          predicate writer leaves last stage this cycle
//   hazard_stall_count     out  COUNTER_WIDTH              cycles issue was blocked by hazard
// BEHAVIOUR
//   Reset (async, while high):
//     - stage_valid=0, stage_dt=0, hazard_stall_count=0.
//     - issue, hazard, predicate_retire read 0; issue is forced 0 while reset is high.
//   hazard (comb., from registers only): OR over i of stage_valid[i] && stage_dt[i]==PREDICATE.
//   issue (comb.): trigger_valid && !hazard && !downstream_stall && !flush.
//   Clock edge, priority order:
//     1. flush=1: stage_valid<=0 and stage_dt<=0, regardless of downstream_stall.
//     2. Else if downstream_stall=1: all stage registers hold.
//     3. Else shift stage[i+1]<=stage[i]; stage 0 loads {1,trigger_dt} if issue, else {0,0}.
//        A bubble always carries DT=0.
//   Last-stage contents are discarded on shift (retired).
//   predicate_retire = stage_valid[N-1] && stage_dt[N-1]==PREDICATE && !downstream_stall && !flush.
//   Timing, no stalls:
//     - Predicate writer issued in cycle t is in stages 0..N-1 during cycles t+1..t+N.
//     - hazard is high during t+1..t+N; next issue is earliest at t+N+1.
//     - Non-predicate issues may go back-to-back every cycle.
//   Each downstream_stall cycle extends the hazard window by one cycle.
//   Invariant (assert): at most one valid stage holds DT==PREDICATE.
//   hazard_stall_count:
//     - +1 on each cycle with trigger_valid && hazard && !downstream_stall && !flush.
//     - Saturates at all-ones; no wrap.
//     - counter_clear=1 loads 0 and wins over a simultaneous increment.
//   Reset mid-operation: all in-flight state lost immediately; the next issue is legal in the
//   first cycle after reset deasserts.
// TESTING
//   1. N=3, trigger_valid=1 each cycle, DTs non-predicate -> issue=1 every cycle;
//      stage_valid=111 from cycle 3.
//   2. Predicate writer issued at t=0, trigger_valid held high ->
//      - hazard=1 and issue=0 in cycles 1..3;
//      - predicate_retire=1 in cycle 3; issue=1 in cycle 4;
//      - hazard_stall_count=3.
//   3. Scenario 2 plus downstream_stall=1 in cycle 2 ->
//      - stages hold in cycle 2; hazard stays high through cycle 4;
//      - issue resumes in cycle 5; count=3 (stall cycle not counted).
//   4. flush in cycle 2 of scenario 2 ->
//      - stage_valid=000 in cycle 3; no predicate_retire; issue=1 in cycle 3.
//   5. COUNTER_WIDTH=2, hazard held 5 cycles -> count sticks at 3.
//      counter_clear with a concurrent increment -> count=0.
//   6. Assert reset with stages full -> outputs 0 immediately (async); clean restart after deassert.

Source files
------------

// File: rtl/predicate_hazard_issue_controller.sv
// rtl/predicate_hazard_issue_controller.sv - trigger-stage issue gating on in-flight predicate writes
// Tracks occupancy and destination type per downstream stage and counts hazard-blocked cycles.
module predicate_hazard_issue_controller #(
  parameter int NUM_DOWNSTREAM_STAGES = 3,
  parameter int COUNTER_WIDTH = 16,
  parameter int TIA_DT_WIDTH = 3,
  parameter logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_PREDICATE = 3'd2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          trigger_valid,
  input  logic [TIA_DT_WIDTH-1:0]                       trigger_dt,
  input  logic                                          downstream_stall,
  input  logic                                          flush,
  input  logic                                          counter_clear,
  output logic                                          issue,
  output logic                                          hazard,
  output logic [NUM_DOWNSTREAM_STAGES-1:0]              stage_valid,
  output logic [NUM_DOWNSTREAM_STAGES*TIA_DT_WIDTH-1:0] stage_dt,
  output logic                                          predicate_retire,
  output logic [COUNTER_WIDTH-1:0]                      hazard_stall_count
);

  localparam int N = NUM_DOWNSTREAM_STAGES;
  localparam int W = TIA_DT_WIDTH;

  logic [N-1:0]             stage_valid_q, stage_valid_d;
  logic [N*W-1:0]           stage_dt_q, stage_dt_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [N-1:0]             pred_hit;
  logic                     count_inc;

  always_comb begin
    pred_hit = '0;
    for (int i = 0; i < N; i++) begin
      pred_hit[i] = stage_valid_q[i] && (stage_dt_q[i*W +: W] == TIA_DESTINATION_TYPE_PREDICATE);
    end
  end

  // Hazard looks only at registered stage state, so issue never depends on itself.
  assign hazard           = |pred_hit;
  assign issue            = !reset && trigger_valid && !hazard && !downstream_stall && !flush;
  assign predicate_retire = pred_hit[N-1] && !downstream_stall && !flush;
  assign count_inc        = trigger_valid && hazard && !downstream_stall && !flush;

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_dt_d    = stage_dt_q;
    if (flush) begin
      stage_valid_d = '0;
      stage_dt_d    = '0;
    end else if (!downstream_stall) begin
      for (int i = N - 1; i > 0; i--) begin
        stage_valid_d[i]       = stage_valid_q[i-1];
        stage_dt_d[i*W +: W]   = stage_dt_q[(i-1)*W +: W];
      end
      stage_valid_d[0]   = issue;
      stage_dt_d[0 +: W] = issue ? trigger_dt : '0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (counter_clear) begin
      count_d = '0;
    end else if (count_inc && (count_q != {COUNTER_WIDTH{1'b1}})) begin
      count_d = count_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid_q <= '0;
      stage_dt_q    <= '0;
      count_q       <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_dt_q    <= stage_dt_d;
      count_q       <= count_d;
    end
  end

  assign stage_valid        = stage_valid_q;
  assign stage_dt           = stage_dt_q;
  assign hazard_stall_count = count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ($countones(pred_hit) <= 1)
        else $error("more than one predicate writer in flight: %b", pred_hit);
    end
  end
`endif

endmodule

// File: tb/tb_predicate_hazard_issue_controller.sv
// tb/tb_predicate_hazard_issue_controller.sv - directed bench for predicate_hazard_issue_controller
module tb_predicate_hazard_issue_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger_valid;
  logic [2:0] trigger_dt;
  logic       downstream_stall;
  logic       flush;
  logic       counter_clear;
  logic       issue, hazard, predicate_retire;
  logic [2:0] stage_valid;
  logic [8:0] stage_dt;
  logic [15:0] hazard_stall_count;
  logic       issue2, hazard2, predicate_retire2;
  logic [2:0] stage_valid2;
  logic [8:0] stage_dt2;
  logic [1:0] count2;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  predicate_hazard_issue_controller dut (
    .clock(clock), .reset(reset), .trigger_valid(trigger_valid), .trigger_dt(trigger_dt),
    .downstream_stall(downstream_stall), .flush(flush), .counter_clear(counter_clear),
    .issue(issue), .hazard(hazard), .stage_valid(stage_valid), .stage_dt(stage_dt),
    .predicate_retire(predicate_retire), .hazard_stall_count(hazard_stall_count)
  );

  predicate_hazard_issue_controller #(.COUNTER_WIDTH(2)) dut_w2 (
    .clock(clock), .reset(reset), .trigger_valid(trigger_valid), .trigger_dt(trigger_dt),
    .downstream_stall(downstream_stall), .flush(flush), .counter_clear(counter_clear),
    .issue(issue2), .hazard(hazard2), .stage_valid(stage_valid2), .stage_dt(stage_dt2),
    .predicate_retire(predicate_retire2), .hazard_stall_count(count2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; trigger_valid = 1'b1; trigger_dt = 3'd1;
    downstream_stall = 1'b0; flush = 1'b0; counter_clear = 1'b0;
    #12;
    check("rst_issue", issue, 0);
    check("rst_hazard", hazard, 0);
    check("rst_valid", stage_valid, 0);
    check("rst_dt", stage_dt, 0);
    check("rst_retire", predicate_retire, 0);
    check("rst_count", hazard_stall_count, 0);
    trigger_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back non-predicate issues
    trigger_valid = 1'b1; trigger_dt = 3'd1; #1;
    check("s1_issue_c0", issue, 1);
    tick(); trigger_dt = 3'd3; #1;
    check("s1_issue_c1", issue, 1);
    check("s1_valid_c1", stage_valid, 3'b001);
    tick(); trigger_dt = 3'd4; #1;
    check("s1_issue_c2", issue, 1);
    check("s1_valid_c2", stage_valid, 3'b011);
    tick(); trigger_valid = 1'b0; #1;
    check("s1_valid_c3", stage_valid, 3'b111);
    check("s1_dt_c3", stage_dt, {3'd1, 3'd3, 3'd4});
    check("s1_hazard_c3", hazard, 0);
    tick(); tick(); tick();
    check("s1_drained", stage_valid, 0);

    // Predicate writer blocks issue for N cycles
    trigger_valid = 1'b1; trigger_dt = 3'd2; #1;
    check("s2_issue_c0", issue, 1);
    tick(); trigger_dt = 3'd1; #1;
    check("s2_hazard_c1", hazard, 1);
    check("s2_issue_c1", issue, 0);
    tick(); #1;
    check("s2_hazard_c2", hazard, 1);
    check("s2_issue_c2", issue, 0);
    check("s2_retire_c2", predicate_retire, 0);
    tick(); #1;
    check("s2_hazard_c3", hazard, 1);
    check("s2_issue_c3", issue, 0);
    check("s2_retire_c3", predicate_retire, 1);
    tick(); #1;
    check("s2_hazard_c4", hazard, 0);
    check("s2_issue_c4", issue, 1);
    check("s2_count", hazard_stall_count, 3);
    check("s2_count_w2", count2, 3);
    trigger_valid = 1'b0;
    tick();

    // Predicate writer with a downstream stall in cycle 2
    trigger_valid = 1'b1; trigger_dt = 3'd2; #1;
    check("s3_issue_c0", issue, 1);
    tick(); trigger_dt = 3'd1; #1;
    check("s3_valid_c1", stage_valid, 3'b001);
    check("s3_issue_c1", issue, 0);
    tick(); downstream_stall = 1'b1; #1;
    check("s3_valid_c2", stage_valid, 3'b010);
    check("s3_hazard_c2", hazard, 1);
    check("s3_issue_c2", issue, 0);
    tick(); downstream_stall = 1'b0; #1;
    check("s3_valid_c3", stage_valid, 3'b010);
    check("s3_hazard_c3", hazard, 1);
    check("s3_retire_c3", predicate_retire, 0);
    tick(); #1;
    check("s3_hazard_c4", hazard, 1);
    check("s3_retire_c4", predicate_retire, 1);
    check("s3_issue_c4", issue, 0);
    tick(); #1;
    check("s3_hazard_c5", hazard, 0);
    check("s3_issue_c5", issue, 1);
    check("s3_count", hazard_stall_count, 6);
    check("s3_count_w2_sat", count2, 3);
    trigger_valid = 1'b0;
    tick();

    // Flush in cycle 2 quashes the predicate writer
    trigger_valid = 1'b1; trigger_dt = 3'd2; #1;
    check("s4_issue_c0", issue, 1);
    tick(); trigger_dt = 3'd1; #1;
    check("s4_hazard_c1", hazard, 1);
    tick(); flush = 1'b1; #1;
    check("s4_issue_c2", issue, 0);
    check("s4_retire_c2", predicate_retire, 0);
    tick(); flush = 1'b0; #1;
    check("s4_valid_c3", stage_valid, 3'b000);
    check("s4_dt_c3", stage_dt, 0);
    check("s4_retire_c3", predicate_retire, 0);
    check("s4_issue_c3", issue, 1);
    check("s4_count", hazard_stall_count, 7);
    trigger_valid = 1'b0;
    tick();

    // Clear wins over a concurrent increment
    trigger_valid = 1'b1; trigger_dt = 3'd2; #1;
    tick(); trigger_dt = 3'd1; counter_clear = 1'b1; #1;
    check("s5_hazard_c1", hazard, 1);
    tick(); counter_clear = 1'b0; #1;
    check("s5_count_clr", hazard_stall_count, 0);
    check("s5_count_w2_clr", count2, 0);
    tick(); trigger_valid = 1'b0; #1;
    check("s5_count_inc", hazard_stall_count, 1);
    tick();

    // Async reset with stages full
    trigger_valid = 1'b1; trigger_dt = 3'd1;
    tick();
    tick(); trigger_dt = 3'd2;
    tick(); trigger_dt = 3'd1; #1;
    check("s6_valid_full", stage_valid, 3'b111);
    check("s6_hazard_full", hazard, 1);
    reset = 1'b1; #1;
    check("s6_rst_valid", stage_valid, 0);
    check("s6_rst_dt", stage_dt, 0);
    check("s6_rst_hazard", hazard, 0);
    check("s6_rst_issue", issue, 0);
    check("s6_rst_retire", predicate_retire, 0);
    check("s6_rst_count", hazard_stall_count, 0);
    #2 reset = 1'b0; #1;
    check("s6_issue_after", issue, 1);
    tick(); trigger_valid = 1'b0; #1;
    check("s6_valid_after", stage_valid, 3'b001);
    check("s6_dt_after", stage_dt, {3'd0, 3'd0, 3'd1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
